// File: rtl/otbn_pq_pkg.sv
// otbn_pq_pkg: shared OTBN PQ types, constants and the Keccak plane unpack helper
package otbn_pq_pkg;
  localparam int PQLEN = 32;
  localparam int KeccakNumPlanes = 5;
  localparam int KeccakLaneW = 64;
  typedef enum logic [1:0] {IDLE, ACC, DONE} keccak_parity_state_e;
  // Lanes 0..3 come from a, lane 4 from b[63:0]; lane x lands at index [x].
  function automatic logic [4:0][KeccakLaneW-1:0] keccak_unpack_plane(
    input logic [PQLEN*8-1:0] a,
    input logic [PQLEN*8-1:0] b
  );
    return {b[KeccakLaneW-1:0], a};
  endfunction
endpackage

// File: rtl/otbn_keccak_column_parity.sv
// otbn_keccak_column_parity: accumulates five Keccak planes into column parity C[x]
// Ports: clk_i/rst_ni (async active-low), clear_i abort, in_valid_i/in_ready_o with
//   in_a_i (lanes 0..3) and in_b_i (lane 4 at [63:0]), out_valid_o/out_ready_i with
//   rs0_o (C[0..3]) and rs1_o (C[4] at [63:0]), plane_cnt_o planes absorbed.
// Build option OTBN_KECCAK_PARITY_SCRUB_EN: zero acc on consume/clear and mask
//   rs0_o/rs1_o whenever no result is valid.
module otbn_keccak_column_parity
  import otbn_pq_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PQLEN*8-1:0] in_a_i,
  input  logic [PQLEN*8-1:0] in_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PQLEN*8-1:0] rs0_o,
  output logic [PQLEN*8-1:0] rs1_o,
  output logic [2:0]         plane_cnt_o
);
`ifdef OTBN_KECCAK_PARITY_SCRUB_EN
  localparam logic ScrubEn = 1'b1;
`else
  localparam logic ScrubEn = 1'b0;
`endif
  keccak_parity_state_e r_state, w_state_nxt;
  logic [4:0][KeccakLaneW-1:0] r_acc, w_acc_nxt, w_plane;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic w_accept, w_consume, w_mask;
  assign w_plane = keccak_unpack_plane(in_a_i, in_b_i);
  assign in_ready_o = r_state != DONE;
  assign out_valid_o = r_state == DONE;
  assign w_accept = in_valid_i & in_ready_o & ~clear_i;
  assign w_consume = out_valid_o & out_ready_i;
  assign w_mask = ScrubEn & ~out_valid_o;
  assign rs0_o = w_mask ? '0 : r_acc[3:0];
  assign rs1_o = w_mask ? '0 : {{(PQLEN*8-KeccakLaneW){1'b0}}, r_acc[4]};
  assign plane_cnt_o = r_cnt;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_acc_nxt = r_acc;
    if (clear_i) begin
      w_state_nxt = IDLE;
      w_cnt_nxt = '0;
      w_acc_nxt = ScrubEn ? '0 : r_acc;
    end else if (w_accept) begin
      // First plane loads rather than XORs, so a stale acc never leaks in.
      w_acc_nxt = (r_state == IDLE) ? w_plane : r_acc ^ w_plane;
      w_cnt_nxt = (r_state == IDLE) ? 3'd1 : r_cnt + 3'd1;
      w_state_nxt = (w_cnt_nxt == 3'(KeccakNumPlanes)) ? DONE : ACC;
    end else if (w_consume) begin
      w_state_nxt = IDLE;
      w_cnt_nxt = '0;
      w_acc_nxt = ScrubEn ? '0 : r_acc;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_acc <= w_acc_nxt;
    end
  end
endmodule

// File: tb/tb_otbn_keccak_column_parity.sv
// tb_otbn_keccak_column_parity: directed and random-chain checks of the column parity block
module tb_otbn_keccak_column_parity;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [255:0] in_a = '0;
  logic [255:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [255:0] rs0, rs1;
  logic [2:0] plane_cnt;
  int n_run = 0;
  int n_fail = 0;

  otbn_keccak_column_parity dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .rs0_o(rs0), .rs1_o(rs1), .plane_cnt_o(plane_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] bcast4(input logic [63:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [319:0] theta(input logic [4:0][63:0] c);
    logic [4:0][63:0] d;
    for (int x = 0; x < 5; x++)
      d[x] = c[(x + 4) % 5] ^ {c[(x + 1) % 5][62:0], c[(x + 1) % 5][63]};
    return d;
  endfunction

  task automatic beat(input logic [255:0] a, input logic [255:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || rs0 !== '0 || rs1 !== '0 || plane_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b rs0=%h rs1=%h cnt=%0d, required 1 0 0 0 0", in_ready, out_valid, rs0, rs1, plane_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int y = 0; y < 5; y++) begin
      n_run++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early_valid beat %0d: got %b required 0", y, out_valid);
      end
      beat(bcast4(64'h1 << y), {192'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE_CAFE_F00D_5555_AAAA, 64'h1 << y});
      if (y == 2) begin
        n_run++;
        if (plane_cnt !== 3'd3) begin
          n_fail++;
          $display("FAIL basic_cnt3: got %0d required 3", plane_cnt);
        end
      end
    end
    n_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid: vld=%b rdy=%b required 1 0", out_valid, in_ready);
    end
    n_run++;
    if (rs0 !== bcast4(64'h1F) || rs1 !== {192'h0, 64'h1F}) begin
      n_fail++;
      $display("FAIL basic_parity: rs0=%h rs1=%h required lanes 1f", rs0, rs1);
    end
    consume();
    n_run++;
    if (out_valid !== 1'b0 || plane_cnt !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_consume: vld=%b cnt=%0d rdy=%b required 0 0 1", out_valid, plane_cnt, in_ready);
    end
  endtask

  task automatic test_identity();
    for (int y = 0; y < 5; y++) beat(bcast4(64'hA5A5_A5A5_A5A5_A5A5), {192'h0, 64'hA5A5_A5A5_A5A5_A5A5});
    n_run++;
    if (rs0 !== bcast4(64'hA5A5_A5A5_A5A5_A5A5) || rs1 !== {192'h0, 64'hA5A5_A5A5_A5A5_A5A5} || plane_cnt !== 3'd5) begin
      n_fail++;
      $display("FAIL identity: rs0=%h rs1=%h cnt=%0d required a5 lanes cnt 5", rs0, rs1, plane_cnt);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    in_a = bcast4(64'hFFFF_0000_FFFF_0000);
    in_b = {192'h0, 64'h1234_5678_9ABC_DEF0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || plane_cnt !== 3'd5 ||
          rs0 !== bcast4(64'hA5A5_A5A5_A5A5_A5A5) || rs1 !== {192'h0, 64'hA5A5_A5A5_A5A5_A5A5}) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: rdy=%b vld=%b cnt=%0d rs0=%h, required 0 1 5 a5 lanes", i, in_ready, out_valid, plane_cnt, rs0);
      end
    end
    in_valid = 1'b0;
    consume();
`ifdef OTBN_KECCAK_PARITY_SCRUB_EN
    n_run++;
    if (rs0 !== '0 || rs1 !== '0) begin
      n_fail++;
      $display("FAIL scrub_after_consume: rs0=%h rs1=%h required 0", rs0, rs1);
    end
`else
    n_run++;
    if (rs0 !== bcast4(64'hA5A5_A5A5_A5A5_A5A5) || rs1 !== {192'h0, 64'hA5A5_A5A5_A5A5_A5A5}) begin
      n_fail++;
      $display("FAIL retain_after_consume: rs0=%h rs1=%h required a5 lanes", rs0, rs1);
    end
`endif
    n_run++;
    if (plane_cnt !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_nobeat: cnt=%0d rdy=%b required 0 1", plane_cnt, in_ready);
    end
  endtask

  task automatic test_abort();
    for (int y = 0; y < 3; y++) beat(bcast4(64'hF0 << y), {192'h0, 64'hF0 << y});
    clear = 1'b1;
    in_valid = 1'b1;
    in_a = bcast4(64'hFFFF);
    in_b = {192'h0, 64'hFFFF};
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    n_run++;
    if (plane_cnt !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_clear: cnt=%0d vld=%b rdy=%b required 0 0 1", plane_cnt, out_valid, in_ready);
    end
    for (int y = 0; y < 5; y++) beat(bcast4(64'h1 << y), {192'h0, 64'h1 << y});
    n_run++;
    if (out_valid !== 1'b1 || rs0 !== bcast4(64'h1F) || rs1 !== {192'h0, 64'h1F}) begin
      n_fail++;
      $display("FAIL abort_result: vld=%b rs0=%h rs1=%h required 1 and lanes 1f", out_valid, rs0, rs1);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_run++;
    if (out_valid !== 1'b0 || plane_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_in_done: vld=%b cnt=%0d required 0 0", out_valid, plane_cnt);
    end
  endtask

  task automatic test_async_reset();
    for (int y = 0; y < 2; y++) beat(bcast4(64'h3C << y), {192'h0, 64'h3C << y});
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || rs0 !== '0 || rs1 !== '0 || plane_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b rs0=%h cnt=%0d required 1 0 0 0", in_ready, out_valid, rs0, plane_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int y = 0; y < 5; y++) beat(bcast4(64'h100 << y), {192'h0, 64'h100 << y});
    n_run++;
    if (out_valid !== 1'b1 || rs0 !== bcast4(64'h1F00) || rs1 !== {192'h0, 64'h1F00}) begin
      n_fail++;
      $display("FAIL reset_then_parity: vld=%b rs0=%h rs1=%h required lanes 1f00", out_valid, rs0, rs1);
    end
    consume();
  endtask

  task automatic test_chain();
    logic [4:0][63:0] pl;
    logic [4:0][63:0] c;
    logic [319:0] d_ref, d_dut;
    int bad = 0;
    for (int v = 0; v < 1000; v++) begin
      c = '0;
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) pl[x] = {$urandom, $urandom};
        c = c ^ pl;
        beat(pl[3:0], {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, pl[4]});
        if (v % 7 == 0) begin
          @(posedge clk);
          #1;
        end
      end
      d_ref = theta(c);
      d_dut = theta({rs1[63:0], rs0});
      n_run++;
      if (out_valid !== 1'b1 || d_dut !== d_ref) begin
        n_fail++;
        bad++;
        if (bad <= 5) $display("FAIL chain_theta vec %0d: vld=%b D=%h required %h", v, out_valid, d_dut[127:0], d_ref[127:0]);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_chain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
